// File: rtl/sq_df_acc_mlane.sv
// rtl/sq_df_acc_mlane.sv - 4-stage multi-lane squared/absolute difference accumulator
// Beats flow S1 |a-b| -> S2 square/extend -> S3 masked lane sum -> S4 saturating accumulate.
module sq_df_acc_mlane #(
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_WIDTH_MUL   = 32,
  parameter int DATA_WIDTH_ACC   = 40,
  parameter int LANES            = 4,
  parameter int HSI_LIBRARY_SIZE = 256,
  localparam int REF_W           = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic                          initial_acc_en,
  input  logic [DATA_WIDTH_ACC-1:0]     initial_acc,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic                          data_in_last,
  input  logic [REF_W-1:0]              data_in_ref,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in_b,
  input  logic [LANES-1:0]              data_in_mask,
  output logic                          acc_valid,
  input  logic                          acc_ready,
  output logic [DATA_WIDTH_ACC-1:0]     acc_value,
  output logic                          acc_last,
  output logic [REF_W-1:0]              acc_ref,
  output logic                          acc_sat
);

  localparam int SUM_W = DATA_WIDTH_MUL + $clog2(LANES);
  localparam int EXT_W = ((DATA_WIDTH_ACC > SUM_W) ? DATA_WIDTH_ACC : SUM_W) + 1;
  // Sideband travelling with each beat: {seed_en, seed, last, ref}
  localparam int SB_W  = 1 + DATA_WIDTH_ACC + 1 + REF_W;

  logic advance;

  logic                                   s1_valid_q, s1_mode_q;
  logic [LANES-1:0]                       s1_mask_q;
  logic [SB_W-1:0]                        s1_side_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]       s1_diff_q, s1_diff_d;

  logic                                   s2_valid_q;
  logic [LANES-1:0]                       s2_mask_q;
  logic [SB_W-1:0]                        s2_side_q;
  logic [LANES-1:0][DATA_WIDTH_MUL-1:0]   s2_term_q, s2_term_d;

  logic                                   s3_valid_q;
  logic [SB_W-1:0]                        s3_side_q;
  logic [SUM_W-1:0]                       s3_sum_q, s3_sum_d;

  logic                                   acc_valid_q, acc_last_q, acc_sat_q, acc_sat_d;
  logic [DATA_WIDTH_ACC-1:0]              acc_value_q, acc_value_d;
  logic [REF_W-1:0]                       acc_ref_q;

  logic                                   s3_seed_en, s3_last;
  logic [DATA_WIDTH_ACC-1:0]              s3_seed, base;
  logic [REF_W-1:0]                       s3_ref;
  logic [EXT_W-1:0]                       total;
  logic                                   overflow;

  // Single global enable: every stage moves together or all hold.
  assign advance       = !acc_valid_q || acc_ready;
  assign data_in_ready = advance;

  always_comb begin
    s1_diff_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (data_in_a[i*DATA_WIDTH +: DATA_WIDTH] >= data_in_b[i*DATA_WIDTH +: DATA_WIDTH])
        s1_diff_d[i] = data_in_a[i*DATA_WIDTH +: DATA_WIDTH] - data_in_b[i*DATA_WIDTH +: DATA_WIDTH];
      else
        s1_diff_d[i] = data_in_b[i*DATA_WIDTH +: DATA_WIDTH] - data_in_a[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    s2_term_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_mode_q)
        s2_term_d[i] = DATA_WIDTH_MUL'(s1_diff_q[i]);
      else
        s2_term_d[i] = DATA_WIDTH_MUL'(s1_diff_q[i]) * DATA_WIDTH_MUL'(s1_diff_q[i]);
    end
  end

  always_comb begin
    s3_sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_mask_q[i])
        s3_sum_d = s3_sum_d + SUM_W'(s2_term_q[i]);
    end
  end

  assign {s3_seed_en, s3_seed, s3_last, s3_ref} = s3_side_q;

  // The output register doubles as the running sum; a closed vector restarts from zero.
  always_comb begin
    base        = s3_seed_en ? s3_seed : (acc_last_q ? '0 : acc_value_q);
    total       = EXT_W'(base) + EXT_W'(s3_sum_q);
    overflow    = |total[EXT_W-1:DATA_WIDTH_ACC];
    acc_value_d = overflow ? '1 : total[DATA_WIDTH_ACC-1:0];
    acc_sat_d   = overflow || (acc_sat_q && !acc_last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_mask_q   <= '0;
      s1_side_q   <= '0;
      s1_diff_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mask_q   <= '0;
      s2_side_q   <= '0;
      s2_term_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_side_q   <= '0;
      s3_sum_q    <= '0;
      acc_valid_q <= 1'b0;
      acc_value_q <= '0;
      acc_last_q  <= 1'b0;
      acc_ref_q   <= '0;
      acc_sat_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= data_in_valid;
      s1_mode_q   <= mode;
      s1_mask_q   <= data_in_mask;
      s1_side_q   <= {initial_acc_en, initial_acc, data_in_last, data_in_ref};
      s1_diff_q   <= s1_diff_d;
      s2_valid_q  <= s1_valid_q;
      s2_mask_q   <= s1_mask_q;
      s2_side_q   <= s1_side_q;
      s2_term_q   <= s2_term_d;
      s3_valid_q  <= s2_valid_q;
      s3_side_q   <= s2_side_q;
      s3_sum_q    <= s3_sum_d;
      acc_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        acc_value_q <= acc_value_d;
        acc_last_q  <= s3_last;
        acc_ref_q   <= s3_ref;
        acc_sat_q   <= acc_sat_d;
      end
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_value = acc_value_q;
  assign acc_last  = acc_last_q;
  assign acc_ref   = acc_ref_q;
  assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_sq_df_acc_mlane.sv
// tb/tb_sq_df_acc_mlane.sv - self-checking bench for sq_df_acc_mlane
// Beat-level model predicts outputs at acceptance; literal values pin the model.
module tb_sq_df_acc_mlane;

  localparam int ACC_W = 40;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n, mode, initial_acc_en, data_in_valid, data_in_ready, data_in_last;
  logic [ACC_W-1:0]  initial_acc, acc_value;
  logic [7:0]        data_in_ref, acc_ref;
  logic [63:0]       data_in_a, data_in_b;
  logic [3:0]        data_in_mask;
  logic              acc_valid, acc_ready, acc_last, acc_sat;

  typedef struct {
    longint v;
    bit     l;
    int     r;
    bit     s;
  } out_t;

  out_t   exp_q[$];
  out_t   obs_q[$];
  longint m_prev;
  bit     m_last, m_sat;
  int     n_chk = 0, n_pass = 0;

  sq_df_acc_mlane #(
    .DATA_WIDTH(16), .DATA_WIDTH_MUL(32), .DATA_WIDTH_ACC(ACC_W),
    .LANES(4), .HSI_LIBRARY_SIZE(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .initial_acc_en(initial_acc_en), .initial_acc(initial_acc),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_in_last(data_in_last), .data_in_ref(data_in_ref),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_mask(data_in_mask),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_value(acc_value),
    .acc_last(acc_last), .acc_ref(acc_ref), .acc_sat(acc_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic longint beat_sum(input bit md, input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] m);
    longint s = 0;
    longint x, y, d;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        x = longint'(a[i*16 +: 16]);
        y = longint'(b[i*16 +: 16]);
        d = (x > y) ? x - y : y - x;
        s += md ? d : d * d;
      end
    end
    return s;
  endfunction

  // Scoreboard and per-cycle checks, sampled on the falling edge.
  always @(negedge clk) begin
    out_t   e;
    longint base, tot;
    if (!rst_n) begin
      exp_q.delete();
      m_prev = 0; m_last = 0; m_sat = 0;
    end else begin
      chk("ready_rule", data_in_ready, !acc_valid || acc_ready);
      if (acc_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q[0];
          chk("acc_value", acc_value, e.v);
          chk("acc_last", acc_last, e.l);
          chk("acc_ref", acc_ref, e.r);
          chk("acc_sat", acc_sat, e.s);
          if (acc_ready) begin
            obs_q.push_back('{v: acc_value, l: acc_last, r: acc_ref, s: acc_sat});
            void'(exp_q.pop_front());
          end
        end
      end
      if (data_in_valid && data_in_ready) begin
        base = initial_acc_en ? longint'(initial_acc) : (m_last ? 0 : m_prev);
        tot  = base + beat_sum(mode, data_in_a, data_in_b, data_in_mask);
        e.v  = (tot > MAXV) ? MAXV : tot;
        e.s  = (tot > MAXV) || (m_sat && !m_last);
        e.l  = data_in_last;
        e.r  = data_in_ref;
        exp_q.push_back(e);
        m_prev = e.v; m_last = e.l; m_sat = e.s;
      end
    end
  end

  task automatic send(input bit md, input logic [63:0] a, input logic [63:0] b, input logic [3:0] m,
                      input bit en, input longint init, input bit last, input int rf);
    int n = 0;
    mode = md; data_in_a = a; data_in_b = b; data_in_mask = m;
    initial_acc_en = en; initial_acc = init[ACC_W-1:0];
    data_in_last = last; data_in_ref = rf[7:0]; data_in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!data_in_ready && n < 100);
    if (n >= 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || acc_valid) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic exp_obs(input string nm, input int idx, input longint v, input bit l, input bit s);
    if (idx >= obs_q.size()) chk({nm, "_missing"}, obs_q.size(), idx + 1);
    else begin
      chk({nm, "_value"}, obs_q[idx].v, v);
      chk({nm, "_last"}, obs_q[idx].l, l);
      chk({nm, "_sat"}, obs_q[idx].s, s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, n;
    rst_n = 0; mode = 0; initial_acc_en = 0; initial_acc = '0; data_in_valid = 0;
    data_in_last = 0; data_in_ref = '0; data_in_a = '0; data_in_b = '0;
    data_in_mask = '0; acc_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_value", acc_value, 0);
    chk("rst_acc_last", acc_last, 0);
    chk("rst_acc_ref", acc_ref, 0);
    chk("rst_acc_sat", acc_sat, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", data_in_ready, 1);
    @(posedge clk); #1;

    // Seeded single beat, squared mode; also pins the latency.
    o0 = obs_q.size();
    send(0, pk(1, 2, 3, 4), pk(0, 0, 0, 0), 4'hf, 1, 10, 1, 5);
    n = 0;
    do begin @(negedge clk); n++; end while (!acc_valid && n < 20);
    chk("latency", n, 4);
    drain();
    exp_obs("seed_sq", o0, 40, 1, 0);
    chk("seed_sq_ref", obs_q[o0].r, 5);

    // Absolute mode with lane 3 masked off.
    o0 = obs_q.size();
    send(1, pk(10, 0, 7, 7), pk(3, 5, 7, 0), 4'b0111, 0, 0, 1, 3);
    drain();
    exp_obs("abs_mask", o0, 12, 1, 0);

    // Three-beat vector with a five-cycle output stall.
    o0 = obs_q.size();
    fork
      begin
        send(0, pk(2, 2, 2, 2), 64'd0, 4'hf, 0, 0, 0, 7);
        send(0, pk(2, 2, 2, 2), 64'd0, 4'hf, 0, 0, 0, 7);
        send(0, pk(2, 2, 2, 2), 64'd0, 4'hf, 0, 0, 1, 7);
      end
      begin
        n = 0;
        while (obs_q.size() < o0 + 1 && n < 50) begin @(posedge clk); #1; n++; end
        acc_ready = 0;
        repeat (5) @(posedge clk);
        #1 acc_ready = 1;
      end
    join
    drain();
    exp_obs("stall_b1", o0, 16, 0, 0);
    exp_obs("stall_b2", o0 + 1, 32, 0, 0);
    exp_obs("stall_b3", o0 + 2, 48, 1, 0);

    // Saturation sticks through the vector, clears on the next.
    o0 = obs_q.size();
    send(1, pk(5, 0, 0, 0), 64'd0, 4'hf, 1, MAXV - 1, 0, 9);
    send(1, pk(1, 0, 0, 0), 64'd0, 4'hf, 0, 0, 1, 9);
    send(1, pk(3, 0, 0, 0), 64'd0, 4'hf, 0, 0, 1, 10);
    drain();
    exp_obs("sat_b1", o0, MAXV, 0, 1);
    exp_obs("sat_b2", o0 + 1, MAXV, 1, 1);
    exp_obs("sat_next", o0 + 2, 3, 1, 0);

    // Back-to-back vectors restart from zero.
    o0 = obs_q.size();
    send(1, pk(1, 0, 0, 0), 64'd0, 4'hf, 0, 0, 0, 1);
    send(1, pk(1, 0, 0, 0), 64'd0, 4'hf, 0, 0, 1, 1);
    send(1, pk(1, 0, 0, 0), 64'd0, 4'hf, 0, 0, 0, 2);
    send(1, pk(1, 0, 0, 0), 64'd0, 4'hf, 0, 0, 1, 2);
    drain();
    exp_obs("b2b_v1a", o0, 1, 0, 0);
    exp_obs("b2b_v1b", o0 + 1, 2, 1, 0);
    exp_obs("b2b_v2a", o0 + 2, 1, 0, 0);
    exp_obs("b2b_v2b", o0 + 3, 2, 1, 0);
    chk("b2b_ref0", obs_q[o0].r, 1);
    chk("b2b_ref3", obs_q[o0 + 3].r, 2);

    // Mode switch mid-vector across bubbles, b > a lane, then full-scale lanes.
    o0 = obs_q.size();
    send(0, pk(3, 1, 0, 0), pk(0, 4, 0, 0), 4'hf, 0, 0, 0, 4);
    repeat (3) @(posedge clk);
    #1;
    send(1, pk(3, 1, 0, 0), pk(0, 4, 0, 0), 4'hf, 0, 0, 1, 4);
    send(0, pk(65535, 65535, 65535, 65535), 64'd0, 4'hf, 0, 0, 1, 4);
    drain();
    exp_obs("mix_b1", o0, 18, 0, 0);
    exp_obs("mix_b2", o0 + 1, 24, 1, 0);
    exp_obs("full_scale", o0 + 2, 64'd17179344900, 1, 0);

    // Reset mid-vector discards the in-flight beat and the running sum.
    o0 = obs_q.size();
    send(0, pk(1, 1, 1, 1), 64'd0, 4'hf, 0, 0, 0, 6);
    drain();
    exp_obs("pre_rst", o0, 4, 0, 0);
    send(0, pk(1, 1, 1, 1), 64'd0, 4'hf, 0, 0, 0, 6);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("midrst_valid", acc_valid, 0);
    chk("midrst_value", acc_value, 0);
    chk("midrst_sat", acc_sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_out", obs_q.size(), o0 + 1);
    send(0, pk(1, 1, 1, 1), 64'd0, 4'hf, 0, 0, 0, 6);
    send(0, pk(1, 1, 1, 1), 64'd0, 4'hf, 0, 0, 1, 6);
    drain();
    exp_obs("post_rst_a", o0 + 1, 4, 0, 0);
    exp_obs("post_rst_b", o0 + 2, 8, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sq_df_acc_mlane.md
SQ_DF_ACC_MLANE -- requirements
Module: sq_df_acc_mlane

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default HSID_DATA_WIDTH (16), unsigned element width.
REQ-002 SHALL have parameter DATA_WIDTH_MUL, default HSID_DATA_WIDTH_MUL (32), per-lane product width, ≥ 2*DATA_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH_ACC, default HSID_DATA_WIDTH_ACC, accumulator width.
REQ-004 SHALL have parameter LANES, default 4, elements per beat, power of two, 1..16.
REQ-005 SHALL have parameter HSI_LIBRARY_SIZE, default HSID_HSI_LIBRARY_SIZE; REF_W = $clog2(HSI_LIBRARY_SIZE).
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-007 SHALL have ports: mode  in  1  distance mode (0 squared difference, 1 absolute difference).
REQ-008 SHALL have ports: initial_acc_en  in  1; initial_acc  in  DATA_WIDTH_ACC  seed for the beat's vector.
REQ-009 SHALL have ports: data_in_valid  in  1; data_in_ready  out  1; data_in_last  in  1; data_in_ref  in  REF_W.
REQ-010 SHALL have ports: data_in_a, data_in_b  in  LANES*DATA_WIDTH  packed elements, lane 0 in LSBs; data_in_mask  in  LANES  lane enable.
REQ-011 SHALL have ports: acc_valid  out  1; acc_ready  in  1; acc_value  out  DATA_WIDTH_ACC; acc_last  out  1; acc_ref  out  REF_W; acc_sat  out  1.
REQ-012 SHALL use one clock with reset asynchronous and active-low: clk, rst_n.

Function
REQ-013 SHALL accept a beat when data_in_valid && data_in_ready.
REQ-014 SHALL implement a 4-stage pipeline: S1 per-lane |a-b|; S2 square (mode 0) or zero-extend (mode 1) to DATA_WIDTH_MUL; S3 sum of masked lanes (width DATA_WIDTH_MUL+$clog2(LANES)); S4 accumulate.
REQ-015 SHALL emit one output per accepted beat, 4 cycles after acceptance when acc_ready stays high.
REQ-016 SHALL drive data_in_ready = !acc_valid || acc_ready; when low, all stages hold (global stall) and no data is lost or duplicated.
REQ-017 SHALL hold acc_value, acc_last, acc_ref and acc_sat stable while acc_valid && !acc_ready.
REQ-018 SHALL carry mode, mask, initial_acc_en/initial_acc, last and ref alongside each beat, sampled at acceptance.
REQ-019 SHALL compute |a-b| unsigned without overflow; masked-off lanes SHALL contribute 0.
REQ-020 S4 base SHALL be initial_acc when the beat's initial_acc_en=1, else 0 if the previous output beat had acc_last=1 or no beat since reset, else the previous acc_value.
REQ-021 SHALL output acc_value = base + S3 sum, saturating at 2^DATA_WIDTH_ACC-1.
REQ-022 acc_sat SHALL be set on the beat that saturates and SHALL stay set for every later beat of the same vector, clearing on the beat after acc_last.
REQ-023 acc_last and acc_ref SHALL equal the beat's data_in_last and data_in_ref.
REQ-024 Back-to-back vectors SHALL need no bubble; the first beat of vector N+1 MAY follow the last beat of vector N directly.
REQ-025 Bubbles (data_in_valid=0) mid-vector SHALL not alter the running sum.
REQ-026 mode changing mid-vector SHALL apply per beat; no error is flagged.

Reset
REQ-027 On rst_n=0, all pipeline valids, acc_valid, acc_value, acc_last, acc_ref and acc_sat SHALL clear to 0 immediately; running sum SHALL clear to 0.
REQ-028 Reset mid-vector SHALL discard in-flight beats; no output SHALL appear until 4 cycles after the first post-reset accepted beat.
REQ-029 data_in_ready SHALL be 1 from the first edge after reset release.

Verification
REQ-030 LANES=4, mode 0, one beat a={1,2,3,4}, b={0,0,0,0}, last=1, initial_acc=10, en=1 -> after 4 cycles acc_value=40, acc_last=1.
REQ-031 mode 1, a={10,0,7,7}, b={3,5,7,0}, mask=4'b0111 -> acc_value=12 (lane 3 ignored).
REQ-032 Vector of 3 beats, each a={2,2,2,2}, b=0, mode 0, no seed, acc_ready low for 5 cycles on beat 2 -> outputs 16, 32, 48 in order, each held while stalled, none lost.
REQ-033 initial_acc=2^DATA_WIDTH_ACC-2, beat sum 5 then beat sum 1, last on beat 2 -> both outputs = max, acc_sat=1 on both; next vector's first output has acc_sat=0.
REQ-034 Two 2-beat vectors back-to-back, ref 1 then 2, no seeds -> second vector restarts from 0, acc_ref follows 1,1,2,2.
REQ-035 Assert rst_n low two cycles after accepting beat 1 of a vector -> no outputs emerge; post-reset vector sums from 0.
